// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares one single-port data memory between two vcore dmem
//                ports (p0, p1). Accesses are serialised onto a req/ack
//                memory bus using round-robin or fixed (p0-first) priority,
//                with direct owner-to-owner hand-off on ack and a saturating
//                contention counter for performance debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             p0_enable_i,
    input  logic             p0_write_i,
    input  logic [AW-1:0]    p0_addr_i,
    input  logic [DW-1:0]    p0_wdata_i,
    output logic [DW-1:0]    p0_rdata_o,
    output logic             p0_valid_o,

    input  logic             p1_enable_i,
    input  logic             p1_write_i,
    input  logic [AW-1:0]    p1_addr_i,
    input  logic [DW-1:0]    p1_wdata_i,
    output logic [DW-1:0]    p1_rdata_o,
    output logic             p1_valid_o,

    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [DW-1:0]    mem_wdata_o,
    input  logic [DW-1:0]    mem_rdata_i,
    input  logic             mem_ack_i,

    output logic [1:0]       grant_o,
    output logic [CNT_W-1:0] contention_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             c_fixed   = (FIXED_PRIO != 0);

    state_t           r_state;
    logic [1:0]       r_grant;     // one-hot owner, bit0 = p0
    logic             r_req;
    logic             r_rr_last;   // 0 = p0 was served last, 1 = p1
    logic [CNT_W-1:0] r_cnt;

    logic             w_p0_wins;
    logic             w_contend;

    // p0 wins an IDLE decision when alone, or on a tie under fixed priority
    // or when p1 was the last port served
    assign w_p0_wins = p0_enable_i & (~p1_enable_i | c_fixed | r_rr_last);

    // A cycle is contended when one port is waiting while the other owns the
    // bus; the owner's own enable (including its stale ack-cycle enable) never counts
    assign w_contend = (r_grant[0] & p1_enable_i) | (r_grant[1] & p0_enable_i);

    // Ownership FSM: registered state, grant and request; direct hand-off on ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_req     <= 1'b0;
            r_rr_last <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_p0_wins) begin
                        r_state <= OWN0;
                        r_grant <= 2'b01;
                        r_req   <= 1'b1;
                    end else if (p1_enable_i) begin
                        r_state <= OWN1;
                        r_grant <= 2'b10;
                        r_req   <= 1'b1;
                    end
                end
                OWN0: begin
                    if (mem_ack_i) begin
                        r_rr_last <= 1'b0;
                        if (p1_enable_i) begin
                            r_state <= OWN1;
                            r_grant <= 2'b10;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                            r_req   <= 1'b0;
                        end
                    end
                end
                OWN1: begin
                    if (mem_ack_i) begin
                        r_rr_last <= 1'b1;
                        if (p0_enable_i) begin
                            r_state <= OWN0;
                            r_grant <= 2'b01;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                            r_req   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating contention counter, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_contend && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Memory bus follows the owner combinationally; zero while idle
    assign mem_req_o   = r_req;
    assign mem_we_o    = (r_grant[0] & p0_write_i) | (r_grant[1] & p1_write_i);
    assign mem_addr_o  = ({AW{r_grant[0]}} & p0_addr_i)  | ({AW{r_grant[1]}} & p1_addr_i);
    assign mem_wdata_o = ({DW{r_grant[0]}} & p0_wdata_i) | ({DW{r_grant[1]}} & p1_wdata_i);

    // Read data is broadcast; only the owner sees the completion pulse
    assign p0_rdata_o  = mem_rdata_i;
    assign p1_rdata_o  = mem_rdata_i;
    assign p0_valid_o  = r_grant[0] & mem_ack_i;
    assign p1_valid_o  = r_grant[1] & mem_ack_i;

    assign grant_o          = r_grant;
    assign contention_cnt_o = r_cnt;

    // The owning port must keep its request up until the memory acknowledges it
    a_p0_hold: assert property (@(posedge clk) disable iff (!reset_n) r_grant[0] |-> p0_enable_i);
    a_p1_hold: assert property (@(posedge clk) disable iff (!reset_n) r_grant[1] |-> p1_enable_i);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Scoreboard bench for dmem_arbiter. Two instances: u_rr
//                (round-robin, 16-bit counter) and u_fx (fixed priority,
//                4-bit counter so saturation is reachable). Port masters push
//                expected transactions into per-port queues on issue; a
//                negedge monitor pops and compares them on completion and
//                checks grant order and the counter against a rule model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            at;
    } txn_t;

    logic clk = 1'b0;
    logic reset_n;

    // Port index k = 2*instance + port
    logic          en    [4];
    logic          wr    [4];
    logic [AW-1:0] addr  [4];
    logic [DW-1:0] wdata [4];
    logic [DW-1:0] rdo   [4];
    logic          vo    [4];

    logic          req    [2];
    logic          we     [2];
    logic [AW-1:0] maddr  [2];
    logic [DW-1:0] mwdata [2];
    logic [DW-1:0] mrdata [2];
    logic          ack    [2];
    logic [1:0]    grant  [2];
    logic [15:0]   cnt_a;
    logic [3:0]    cnt_b;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0), .CNT_W(16)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .p0_enable_i(en[0]), .p0_write_i(wr[0]), .p0_addr_i(addr[0]), .p0_wdata_i(wdata[0]),
        .p0_rdata_o(rdo[0]), .p0_valid_o(vo[0]),
        .p1_enable_i(en[1]), .p1_write_i(wr[1]), .p1_addr_i(addr[1]), .p1_wdata_i(wdata[1]),
        .p1_rdata_o(rdo[1]), .p1_valid_o(vo[1]),
        .mem_req_o(req[0]), .mem_we_o(we[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]),
        .mem_rdata_i(mrdata[0]), .mem_ack_i(ack[0]),
        .grant_o(grant[0]), .contention_cnt_o(cnt_a)
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1), .CNT_W(4)) u_fx (
        .clk(clk), .reset_n(reset_n),
        .p0_enable_i(en[2]), .p0_write_i(wr[2]), .p0_addr_i(addr[2]), .p0_wdata_i(wdata[2]),
        .p0_rdata_o(rdo[2]), .p0_valid_o(vo[2]),
        .p1_enable_i(en[3]), .p1_write_i(wr[3]), .p1_addr_i(addr[3]), .p1_wdata_i(wdata[3]),
        .p1_rdata_o(rdo[3]), .p1_valid_o(vo[3]),
        .mem_req_o(req[1]), .mem_we_o(we[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]),
        .mem_rdata_i(mrdata[1]), .mem_ack_i(ack[1]),
        .grant_o(grant[1]), .contention_cnt_o(cnt_b)
    );

    // Bench state
    int      errors = 0;
    int      checks = 0;
    int      cyc    = 0;
    txn_t    plan [4][$];
    txn_t    expq [4][$];
    logic    done [4];
    bit      rnd_on [2];
    int      wait_cfg [2];
    int      wcnt [2];
    int      vcount [4];
    logic [DW-1:0] last_rd [4];
    int      idle_cnt [2];
    int      ack_owner [2][$];
    logic    ack_we [2][$];
    logic [AW-1:0] ack_addr [2][$];
    logic [DW-1:0] ack_wdata [2][$];

    // Reference model state
    int      m_own [2];
    int      m_rr  [2];
    longint  m_cnt [2];

    // Memory behaves as a ROM-like responder: read data is a fixed function of address
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return a ^ 16'hBEAF;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Port masters and memory responders
    initial begin
        txn_t t;
        for (int k = 0; k < 4; k++) begin
            en[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
            done[k] = 1'b0; vcount[k] = 0; last_rd[k] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            ack[i] = 1'b0; mrdata[i] = '0; wcnt[i] = -1;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < 4; k++) begin
                if (rnd_on[k/2] && plan[k].size() == 0 && $urandom_range(0, 2) != 0) begin
                    t.wr    = 1'($urandom_range(0, 1));
                    t.addr  = 16'($urandom);
                    t.wdata = 16'($urandom);
                    t.at    = cyc;
                    plan[k].push_back(t);
                end
                if (!en[k] || done[k]) begin
                    if (plan[k].size() > 0 && plan[k][0].at <= cyc) begin
                        t = plan[k].pop_front();
                        en[k] = 1'b1; wr[k] = t.wr; addr[k] = t.addr; wdata[k] = t.wdata;
                        expq[k].push_back(t);
                    end else begin
                        en[k] = 1'b0;
                    end
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (req[i]) begin
                    if (wcnt[i] < 0)
                        wcnt[i] = (wait_cfg[i] < 0) ? int'($urandom_range(0, 3)) : wait_cfg[i];
                    if (wcnt[i] == 0) begin
                        ack[i] = 1'b1; mrdata[i] = mem_f(maddr[i]); wcnt[i] = -1;
                    end else begin
                        ack[i] = 1'b0; mrdata[i] = 16'($urandom); wcnt[i]--;
                    end
                end else begin
                    // stray acks while idle must be ignored
                    ack[i] = 1'($urandom_range(0, 1)); mrdata[i] = 16'($urandom); wcnt[i] = -1;
                end
            end
        end
    end

    // Monitor: scoreboard pops plus rule-model checks, once per cycle at negedge
    initial begin
        int     own, k, oth;
        longint act_cnt, cap;
        logic   expv;
        txn_t   t;
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_rr[i] = 1; m_cnt[i] = 0; idle_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                act_cnt = (i == 0) ? longint'(cnt_a) : longint'(cnt_b);
                cap     = (i == 0) ? 64'd65535 : 64'd15;
                if (!reset_n) begin
                    m_own[i] = -1; m_rr[i] = 1; m_cnt[i] = 0;
                    chk($sformatf("rst_grant[%0d]", i), grant[i], 0);
                    chk($sformatf("rst_req[%0d]", i), req[i], 0);
                    chk($sformatf("rst_we[%0d]", i), we[i], 0);
                    chk($sformatf("rst_addr[%0d]", i), maddr[i], 0);
                    chk($sformatf("rst_wdata[%0d]", i), mwdata[i], 0);
                    chk($sformatf("rst_valid0[%0d]", i), vo[2*i], 0);
                    chk($sformatf("rst_valid1[%0d]", i), vo[2*i+1], 0);
                    chk($sformatf("rst_cnt[%0d]", i), act_cnt, 0);
                    done[2*i] = 1'b0; done[2*i+1] = 1'b0;
                end else begin
                    own = m_own[i];
                    chk($sformatf("grant[%0d]", i), grant[i], (own < 0) ? 0 : (own == 0 ? 1 : 2));
                    chk($sformatf("req[%0d]", i), req[i], (own >= 0) ? 1 : 0);
                    if (own >= 0) begin
                        k = 2*i + own;
                        chk($sformatf("sb_pending[%0d]", k), (expq[k].size() > 0) ? 1 : 0, 1);
                        if (expq[k].size() > 0) begin
                            t = expq[k][0];
                            chk($sformatf("bus_we[%0d]", i), we[i], t.wr);
                            chk($sformatf("bus_addr[%0d]", i), maddr[i], t.addr);
                            chk($sformatf("bus_wdata[%0d]", i), mwdata[i], t.wdata);
                        end
                    end else begin
                        chk($sformatf("idle_we[%0d]", i), we[i], 0);
                        chk($sformatf("idle_addr[%0d]", i), maddr[i], 0);
                        chk($sformatf("idle_wdata[%0d]", i), mwdata[i], 0);
                    end
                    for (int x = 0; x < 2; x++) begin
                        k = 2*i + x;
                        expv = (own == x) && ack[i];
                        chk($sformatf("valid[%0d]", k), vo[k], expv);
                        chk($sformatf("rdata_bcast[%0d]", k), rdo[k], mrdata[i]);
                        done[k] = en[k] && vo[k];
                        if (vo[k]) begin
                            vcount[k]++;
                            last_rd[k] = rdo[k];
                        end
                        if (expv && expq[k].size() > 0) begin
                            t = expq[k].pop_front();
                            if (!t.wr) chk($sformatf("rd_data[%0d]", k), rdo[k], mem_f(t.addr));
                        end
                    end
                    if (own >= 0 && ack[i]) begin
                        ack_owner[i].push_back(own);
                        ack_we[i].push_back(we[i]);
                        ack_addr[i].push_back(maddr[i]);
                        ack_wdata[i].push_back(mwdata[i]);
                    end
                    if (grant[i] == 2'b00) idle_cnt[i]++;
                    chk($sformatf("cnt[%0d]", i), act_cnt, m_cnt[i]);

                    // Rules: a waiting port counts while the other owns; IDLE
                    // picks the single requester, or on a tie p0 (fixed) or the
                    // port not served last; on ack hand to the other port if it waits
                    if (own >= 0 && en[2*i + 1 - own] && m_cnt[i] < cap) m_cnt[i]++;
                    if (own < 0) begin
                        if (en[2*i] && en[2*i+1]) m_own[i] = (i == 1 || m_rr[i] == 1) ? 0 : 1;
                        else if (en[2*i]) m_own[i] = 0;
                        else if (en[2*i+1]) m_own[i] = 1;
                    end else if (ack[i]) begin
                        oth = 1 - own;
                        m_rr[i] = own;
                        m_own[i] = en[2*i + oth] ? oth : -1;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int i, input string nm);
        int n = 0;
        while (n < 300 && !(plan[2*i].size() == 0 && plan[2*i+1].size() == 0 &&
                            !en[2*i] && !en[2*i+1] && grant[i] == 2'b00)) begin
            @(posedge clk); #4; n++;
        end
        chk({"idle_timeout_", nm}, (n < 300) ? 1 : 0, 1);
    endtask

    function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int at);
        txn_t t;
        t.wr = w; t.addr = a; t.wdata = d; t.at = at;
        return t;
    endfunction

    // Directed sequence, then randomized traffic
    initial begin
        int     base, a0, n;
        int     v0, v1, id0;
        longint c0;
        reset_n = 1'b0;
        rnd_on[0] = 1'b0; rnd_on[1] = 1'b0;
        wait_cfg[0] = 1; wait_cfg[1] = 1;

        // Reset with both enables high on u_rr; p0 must win the first tie
        plan[0].push_back(mk(1'b0, 16'h0010, 16'h0, 0));
        plan[1].push_back(mk(1'b0, 16'h0020, 16'h0, 0));
        repeat (3) @(posedge clk);
        #3;
        chk("rst_en_high_grant", grant[0], 0);
        chk("rst_en_high_req", req[0], 0);
        reset_n = 1'b1;
        wait_idle(0, "reset");
        chk("rst_first_owner", (ack_owner[0].size() > 0) ? ack_owner[0][0] : -1, 0);
        chk("rst_second_owner", (ack_owner[0].size() > 1) ? ack_owner[0][1] : -1, 1);

        // Single read from p0 with a slow memory
        wait_cfg[0] = 3;
        c0 = longint'(cnt_a); v1 = vcount[1]; v0 = vcount[0];
        plan[0].push_back(mk(1'b0, 16'h0040, 16'h0, cyc + 1));
        wait_idle(0, "single");
        chk("single_rd_data", last_rd[0], 16'hBEEF);
        chk("single_rd_count", vcount[0] - v0, 1);
        chk("single_p1_quiet", vcount[1] - v1, 0);
        chk("single_cnt", longint'(cnt_a) - c0, 0);

        // Continuous streams from both ports into a zero-wait memory
        wait_cfg[0] = 0;
        base = cyc;
        a0 = base + 2;
        for (int j = 0; j < 16; j++) begin
            plan[0].push_back(mk(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), a0));
            plan[1].push_back(mk(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), a0));
        end
        while (cyc < a0 + 4) begin @(posedge clk); #4; end
        v0 = vcount[0]; v1 = vcount[1]; id0 = idle_cnt[0];
        while (cyc < a0 + 24) begin @(posedge clk); #4; end
        chk("stream_p0_rate", vcount[0] - v0, 10);
        chk("stream_p1_rate", vcount[1] - v1, 10);
        chk("stream_no_bubble", idle_cnt[0] - id0, 0);
        wait_idle(0, "stream");

        // Fixed priority: simultaneous arrival, p0 first, then p1's write
        wait_cfg[1] = 1;
        ack_owner[1].delete(); ack_we[1].delete(); ack_addr[1].delete(); ack_wdata[1].delete();
        base = cyc;
        plan[2].push_back(mk(1'b0, 16'h0200, 16'h0, base + 2));
        plan[3].push_back(mk(1'b1, 16'h0100, 16'h1234, base + 2));
        wait_idle(1, "fixed");
        chk("fx_acks", ack_owner[1].size(), 2);
        if (ack_owner[1].size() == 2) begin
            chk("fx_first", ack_owner[1][0], 0);
            chk("fx_second", ack_owner[1][1], 1);
            chk("fx_wr_we", ack_we[1][1], 1);
            chk("fx_wr_addr", ack_addr[1][1], 16'h0100);
            chk("fx_wr_wdata", ack_wdata[1][1], 16'h1234);
        end

        // Contention: p1 waits five cycles while p0 holds a slow access
        wait_cfg[0] = 5;
        c0 = longint'(cnt_a);
        base = cyc;
        plan[0].push_back(mk(1'b0, 16'h0300, 16'h0, base + 2));
        plan[1].push_back(mk(1'b0, 16'h0304, 16'h0, base + 4));
        wait_idle(0, "contention");
        chk("contention_delta", longint'(cnt_a) - c0, 5);

        // Reset in the middle of a p1 access
        wait_cfg[0] = 6;
        v1 = vcount[1];
        base = cyc;
        plan[1].push_back(mk(1'b1, 16'h0400, 16'h5A5A, base + 2));
        n = 0;
        while (n < 20 && grant[0] != 2'b10) begin @(posedge clk); #4; n++; end
        chk("mid_rst_got_own1", (n < 20) ? 1 : 0, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_async", req[0], 0);
        chk("mid_rst_grant_async", grant[0], 0);
        chk("mid_rst_no_valid", vo[1], 0);
        wait_cfg[0] = 2;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        wait_idle(0, "mid_rst");
        chk("mid_rst_rearb_done", vcount[1] - v1, 1);

        // Randomized traffic on both instances
        wait_cfg[0] = -1; wait_cfg[1] = -1;
        rnd_on[0] = 1'b1; rnd_on[1] = 1'b1;
        repeat (600) @(posedge clk);
        #4;
        rnd_on[0] = 1'b0; rnd_on[1] = 1'b0;
        wait_idle(0, "rand0");
        wait_idle(1, "rand1");
        chk("sat_cnt_b", cnt_b, 4'hF);
        for (int k = 0; k < 4; k++) chk($sformatf("drain[%0d]", k), expq[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
